des_result_serializer: RTL
==========================

Name: des_result_serializer

Overview:
- Downstream of the 16-round DES counter/latch stage.
- Detects the rising edge of that stage's finish flag and captures its 64-bit result block into a small FIFO.
- Streams each block out MSB-byte-first over a valid/ready byte interface toward the chip I/O or wishbone side.
- Reports occupancy and sticky overflow when blocks arrive faster than the consumer drains them.

Parameters:
- DATA_W, 64, block width in bits; must be a multiple of 8.
- DEPTH, 2, FIFO depth in blocks; power of 2, minimum 2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_Clear  input  1  synchronous clear: flush FIFO, zero byte index, clear o_Overflow
- finish  input  1  round-counter finish flag; level, stays high until the next init
- i_Data  input  DATA_W  result block; valid whenever finish is high
- o_Byte  output  8  current output byte
- o_Valid  output  1  o_Byte valid
- i_Ready  input  1  consumer accepts o_Byte this cycle
- o_Last  output  1  high with o_Valid on the final byte of a block
- o_Count  output  $clog2(DEPTH+1)  blocks held (0..DEPTH)
- o_Overflow  output  1  sticky: a block was dropped because the FIFO was full

Behaviour:
- Reset (async, reset=1): FIFO empty, write/read pointers 0, byte index 0, finish_q 0, o_Overflow 0. Outputs are then o_Valid 0, o_Last 0, o_Count 0, o_Byte 0.
- Edge detect: finish_q is the registered copy of finish. Capture request cap = finish & ~finish_q.
  - A held-high finish produces exactly one capture.
  - finish already high when reset is released produces one capture on the first clock after release.
- Write on cap:
  - i_Data is written at the head+count slot on the same edge.
  - Latency: finish sampled high at edge k means o_Valid is high after edge k.
- Read:
  - o_Valid = (count != 0).
  - o_Byte = head block bits [DATA_W-1-8*idx -: 8], where idx = byte index 0..DATA_W/8-1. o_Byte is 0 when empty.
  - o_Byte is driven from registered storage only, so it is stable while o_Valid & ~i_Ready.
- Transfer = o_Valid & i_Ready:
  - idx increments.
  - On idx == DATA_W/8-1: idx returns to 0, head pops, and o_Last is high during that byte.
- Full handling:
  - cap when count == DEPTH and no pop in the same cycle: block dropped, o_Overflow set to 1, FIFO unchanged.
  - cap with a simultaneous pop while full: accepted, count unchanged.
- Simultaneous cap and non-final-byte transfer: both take effect; count increments.
- Pointers wrap modulo DEPTH. count is a separate DEPTH+1-state register; no full/empty ambiguity.
- i_Clear:
  - Has priority over cap and transfer in that cycle.
  - count 0, pointers 0, idx 0, o_Overflow 0.
  - finish_q still updates, so a finish that stays high is not recaptured after the clear.
- o_Overflow is cleared only by reset or i_Clear.
- Reset mid-stream: partial block is discarded; no byte repeats after reset.

Optional Feature:
- Macro: DES_SER_PARITY_EN.
- Defined:
  - Adds output o_Parity (1 bit) = odd parity of o_Byte (~^o_Byte), valid with o_Valid.
  - Adds sticky output o_ParErr (1 bit): set when a transferred byte of any block has LSB != odd parity of its upper 7 bits (DES key-parity check on the byte stream).
  - o_ParErr clears on reset or i_Clear. Both outputs are 0 at reset.
- Undefined: neither port exists; no parity logic is built.

Test Plan:
- Basic stream: reset, finish 0->1 with i_Data=64'h0123456789ABCDEF, i_Ready=1 -> o_Valid from next cycle; bytes 01,23,45,67,89,AB,CD,EF on consecutive cycles; o_Last with EF; o_Count returns to 0.
- Backpressure: same block, i_Ready toggled 1,0,0,1,... -> o_Byte holds 23 across the stalled cycles; no byte lost or duplicated; exactly 8 transfers.
- Level finish: finish held high 40 cycles, i_Ready=0 -> o_Count=1 only; then init drops finish, finish rises again with 64'hFFFF0000FFFF0000 -> o_Count=2.
- Overflow: DEPTH=2, i_Ready=0, three finish edges with blocks A, B, C -> o_Count=2, o_Overflow=1; draining yields A then B, C never appears; i_Clear -> o_Overflow=0, o_Count=0.
- Simultaneous: FIFO full, cap coincides with final-byte transfer of the head -> new block accepted, o_Count stays 2, o_Overflow stays 0.
- Async reset mid-block after 3 bytes of 64'h1122334455667788 -> o_Valid=0 immediately; next block streams from its MSB byte (with DES_SER_PARITY_EN: byte 8'h01 gives o_Parity=0, byte 8'h00 gives o_Parity=1).

Source files
------------

// File: rtl/des_result_serializer.sv
// Captures DES result blocks on the rising edge of finish into a small FIFO and
// streams them MSB-byte-first over valid/ready. Optional parity: DES_SER_PARITY_EN.
module des_result_serializer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_Clear,
  input  logic                       finish,
  input  logic [DATA_W-1:0]          i_Data,
  output logic [7:0]                 o_Byte,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic                       o_Last,
  output logic [$clog2(DEPTH+1)-1:0] o_Count,
  output logic                       o_Overflow
`ifdef DES_SER_PARITY_EN
  ,
  output logic                       o_Parity,
  output logic                       o_ParErr
`endif
);

  localparam int NBYTES = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  idx;
  logic              finish_q;
  logic              overflow;
  logic              cap;
  logic              xfer;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] head_blk;
  logic [DATA_W-1:0] head_shift;

  assign cap     = finish & ~finish_q;
  assign o_Valid = (count != '0);
  assign xfer    = o_Valid & i_Ready;
  assign pop     = xfer & (idx == LAST_IDX);
  // A full FIFO still accepts a new block when the head leaves on the same edge.
  assign push    = cap & ((count != FULL) | pop);
  assign drop    = cap & (count == FULL) & ~pop;
  assign wr_ptr  = head + PTR_W'(count);

  assign head_blk   = mem[head];
  assign head_shift = head_blk << {idx, 3'b000};
  assign o_Byte     = o_Valid ? head_shift[DATA_W-1 -: 8] : 8'h00;
  assign o_Last     = o_Valid & (idx == LAST_IDX);
  assign o_Count    = count;
  assign o_Overflow = overflow;

  // Control state: edge detector, pointers, occupancy, byte index, sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish_q <= 1'b0;
      head     <= '0;
      count    <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      finish_q <= finish;
      if (i_Clear) begin
        head     <= '0;
        count    <= '0;
        idx      <= '0;
        overflow <= 1'b0;
      end else begin
        if (xfer)
          idx <= pop ? '0 : idx + IDX_W'(1);
        if (pop)
          head <= head + PTR_W'(1);
        if (push & ~pop)
          count <= count + CNT_W'(1);
        else if (pop & ~push)
          count <= count - CNT_W'(1);
        if (drop)
          overflow <= 1'b1;
      end
    end
  end

  // Block storage: data path only, never reset
  always_ff @(posedge clk) begin
    if (push & ~i_Clear)
      mem[wr_ptr] <= i_Data;
  end

`ifdef DES_SER_PARITY_EN
  logic par_err;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // A DES key byte is well-formed when its total bit count is odd.
  function automatic logic key_byte_bad(input logic [7:0] b);
    return ~(^b);
  endfunction

  assign o_Parity = o_Valid & odd_parity(o_Byte);
  assign o_ParErr = par_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      par_err <= 1'b0;
    else if (i_Clear)
      par_err <= 1'b0;
    else if (xfer & key_byte_bad(o_Byte))
      par_err <= 1'b1;
  end
`endif

endmodule
